// File: rtl/hist_readout_streamer.sv
// Histogram readout streamer: walks every bin over a sync read port and emits a framed byte stream.
// Latency: first byte (HDR) valid 1 cycle after start is sampled in IDLE; 2-cycle bubble (RD, WT) between bins.
// Backpressure: tx_valid/tx_ready; a presented byte holds stable until accepted, FSM stalls otherwise.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   start               begin a frame (sampled only in IDLE)
//   busy, done          frame in progress / one-cycle completion pulse
//   rd_en, rd_addr      read strobe and bin index to the histogram RAM
//   rd_data             bin count, valid one cycle after rd_en
//   tx_data, tx_valid   stream byte out
//   tx_ready            downstream accepts byte on tx_valid && tx_ready
//
// Optional feature macro: HIST_STREAM_CKSUM_EN adds a trailing XOR checksum byte.
// Frame: HDR_BYTE, NUM_OUT[7:0], per bin CNT_W/8 count bytes MSB first, [checksum].

module hist_readout_streamer #(
    parameter int         NUM_OUT  = 8,
    parameter int         CNT_W    = 32,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [NUM_OUT-1:0] rd_addr,
    input  logic [CNT_W-1:0]   rd_data,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready
);

    localparam int                 NBYTES    = CNT_W / 8;
    localparam int                 BCW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BCW-1:0]     LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [NUM_OUT-1:0] LAST_BIN  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN,
        S_RD,
        S_WT,
        S_TXB,
`ifdef HIST_STREAM_CKSUM_EN
        S_CK,
`endif
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] shreg;
    logic [BCW-1:0]   byte_cnt;
    logic             hs;
    logic             last_byte;

    assign hs        = tx_valid && tx_ready;
    assign last_byte = (byte_cnt == LAST_BYTE);

`ifdef HIST_STREAM_CKSUM_EN
    logic [7:0] cksum;

    // Running XOR of every byte accepted from HDR through the last count byte.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cksum <= '0;
        end else if (state == S_IDLE && start) begin
            cksum <= '0;
        end else if (hs && state != S_CK) begin
            cksum <= cksum ^ tx_data;
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: address walker, count shift register, per-bin byte counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_addr  <= '0;
            shreg    <= '0;
            byte_cnt <= '0;
        end else begin
            case (state)
                S_WT: begin
                    // rd_data is only trusted here, one cycle after the RD strobe.
                    shreg    <= rd_data;
                    byte_cnt <= '0;
                end
                S_TXB: begin
                    if (hs) begin
                        shreg    <= shreg << 8;
                        byte_cnt <= byte_cnt + BCW'(1);
                        // Last bin leaves rd_addr in place; DONE clears it, so it never wraps.
                        if (last_byte && rd_addr != LAST_BIN) begin
                            rd_addr <= rd_addr + NUM_OUT'(1);
                        end
                    end
                end
                S_DONE: rd_addr <= '0;
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_HDR;
            S_HDR:  if (hs) state_nxt = S_LEN;
            S_LEN:  if (hs) state_nxt = S_RD;
            S_RD:   state_nxt = S_WT;
            S_WT:   state_nxt = S_TXB;
            S_TXB: begin
                if (hs && last_byte) begin
                    if (rd_addr == LAST_BIN) begin
`ifdef HIST_STREAM_CKSUM_EN
                        state_nxt = S_CK;
`else
                        state_nxt = S_DONE;
`endif
                    end else begin
                        state_nxt = S_RD;
                    end
                end
            end
`ifdef HIST_STREAM_CKSUM_EN
            S_CK:   if (hs) state_nxt = S_DONE;
`endif
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state; tx_data only changes with state/shreg, which hold while stalled.
    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        rd_en    = (state == S_RD);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state)
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = HDR_BYTE;
            end
            S_LEN: begin
                tx_valid = 1'b1;
                tx_data  = 8'(NUM_OUT);
            end
            S_TXB: begin
                tx_valid = 1'b1;
                tx_data  = shreg[CNT_W-1 -: 8];
            end
`ifdef HIST_STREAM_CKSUM_EN
            S_CK: begin
                tx_valid = 1'b1;
                tx_data  = cksum;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hist_readout_streamer.sv
// Self-checking bench for hist_readout_streamer (NUM_OUT=2, CNT_W=16).
// Latency: n/a. Backpressure: tx_ready randomised at a configurable duty.
// A RAM model answers reads; frames are compared with a byte-list reference built from the bin array.

module tb_hist_readout_streamer;

    localparam int NUM_OUT = 2;
    localparam int CNT_W   = 16;
    localparam int NBINS   = 4;
    localparam int NBY     = 2;
`ifdef HIST_STREAM_CKSUM_EN
    localparam int         LIT_LEN  = 11;
    localparam logic [7:0] LIT_LAST = 8'hA7;
`else
    localparam int         LIT_LEN  = 10;
    localparam logic [7:0] LIT_LAST = 8'hFF;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic               busy;
    logic               done;
    logic               rd_en;
    logic [NUM_OUT-1:0] rd_addr;
    logic [CNT_W-1:0]   rd_data;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;

    always #5 clk = ~clk;

    hist_readout_streamer #(
        .NUM_OUT (NUM_OUT),
        .CNT_W   (CNT_W),
        .HDR_BYTE(8'hA5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ready_pct = 100;

    logic [CNT_W-1:0] mem [NBINS];
    logic [7:0]       rx[$];
    logic [7:0]       exp_q[$];
    int               rd_seen[$];
    int               done_cnt   = 0;
    int               rd_wide    = 0;
    int               stall_viol = 0;
    int               idle_read  = 0;
    logic             prev_stall = 1'b0;
    logic             prev_rd_en = 1'b0;
    logic [7:0]       prev_data  = 8'h00;

    // Synchronous RAM: data one cycle after rd_en, garbage on every other cycle.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        else       rd_data <= CNT_W'($urandom);
    end

    initial tx_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        tx_ready = (int'($urandom_range(99)) < ready_pct);
    end

    // Passive monitor on the falling edge.
    always @(negedge clk) begin
        if (tx_valid && tx_ready) rx.push_back(tx_data);
        if (reset_n && prev_stall && !(tx_valid && tx_data == prev_data)) stall_viol++;
        prev_stall = reset_n && tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (rd_en) begin
            rd_seen.push_back(int'(rd_addr));
            if (prev_rd_en) rd_wide++;
            if (!busy) idle_read++;
        end
        prev_rd_en = rd_en;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference frame straight from the frame format definition.
    task automatic build_exp();
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(NUM_OUT));
        for (int b = 0; b < NBINS; b++)
            for (int k = NBY - 1; k >= 0; k--)
                exp_q.push_back(mem[b][8*k +: 8]);
`ifdef HIST_STREAM_CKSUM_EN
        x = 8'h00;
        foreach (exp_q[i]) x = x ^ exp_q[i];
        exp_q.push_back(x);
`else
        x = 8'h00;
`endif
    endtask

    task automatic check_frame(input string tag, input int rxb, input int rdb, input int doneb,
                               input int wideb, input int stallb, input int idleb);
        check({tag, "_len"}, 64'(rx.size() - rxb), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (rxb + i < rx.size())
                check($sformatf("%s_byte%0d", tag, i), 64'(rx[rxb+i]), 64'(exp_q[i]));
        check({tag, "_nreads"}, 64'(rd_seen.size() - rdb), 64'(NBINS));
        for (int i = 0; i < NBINS; i++)
            if (rdb + i < rd_seen.size())
                check($sformatf("%s_raddr%0d", tag, i), 64'(rd_seen[rdb+i]), 64'(i));
        check({tag, "_ndone"}, 64'(done_cnt - doneb), 64'd1);
        check({tag, "_rdwide"}, 64'(rd_wide - wideb), 64'd0);
        check({tag, "_stable"}, 64'(stall_viol - stallb), 64'd0);
        check({tag, "_idleread"}, 64'(idle_read - idleb), 64'd0);
    endtask

    // Wait for done (bounded), optionally re-pulsing start while busy, then check the frame.
    task automatic finish_frame(input string tag, input bit bump, input int rxb, input int rdb,
                                input int doneb, input int wideb, input int stallb, input int idleb);
        int cyc;
        cyc = 0;
        while (done_cnt == doneb && cyc < 3000) begin
            @(posedge clk); #1;
            start = (bump && busy && rd_addr != 2'd3) ? 1'($urandom_range(1)) : 1'b0;
            cyc++;
        end
        start = 1'b0;
        if (done_cnt == doneb) check({tag, "_timeout"}, 64'd0, 64'd1);
        repeat (3) begin @(posedge clk); #1; end
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        check_frame(tag, rxb, rdb, doneb, wideb, stallb, idleb);
    endtask

    task automatic run_frame(input string tag, input int pct, input bit bump);
        int rxb, rdb, doneb, wideb, stallb, idleb;
        build_exp();
        rxb = rx.size(); rdb = rd_seen.size(); doneb = done_cnt;
        wideb = rd_wide; stallb = stall_viol; idleb = idle_read;
        ready_pct = pct;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_lat_valid"}, 64'(tx_valid), 64'd1);
        check({tag, "_lat_hdr"}, 64'(tx_data), 64'hA5);
        check({tag, "_lat_busy"}, 64'(busy), 64'd1);
        finish_frame(tag, bump, rxb, rdb, doneb, wideb, stallb, idleb);
    endtask

    initial begin
        int rxb, rdb, doneb, wideb, stallb, idleb, cyc;
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        reset_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Fixed bins, full-rate sink.
        mem[0] = 16'h0001; mem[1] = 16'h0203; mem[2] = 16'h0000; mem[3] = 16'hFFFF;
        run_frame("t1", 100, 1'b0);
        check("t1_total", 64'(rx.size()), 64'(LIT_LEN));
        if (rx.size() > 0) check("t1_last", 64'(rx[rx.size()-1]), 64'(LIT_LAST));

        // Same bins, 30% ready duty.
        run_frame("t2", 30, 1'b0);

        // Random bins, random duty, start re-pulsed while busy.
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < NBINS; b++) mem[b] = CNT_W'($urandom);
            run_frame($sformatf("t3r%0d", f), int'($urandom_range(100, 20)), 1'b1);
        end

        // start held high: next frame follows DONE through one IDLE cycle.
        build_exp();
        ready_pct = 70;
        rxb = rx.size(); rdb = rd_seen.size(); doneb = done_cnt;
        wideb = rd_wide; stallb = stall_viol; idleb = idle_read;
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
        if (!done) check("t3h_timeout", 64'd0, 64'd1);
        @(negedge clk);
        check("t3h_idle_busy", 64'(busy), 64'd0);
        check_frame("t3h_f1", rxb, rdb, doneb, wideb, stallb, idleb);
        rxb = rx.size(); rdb = rd_seen.size(); doneb = done_cnt;
        wideb = rd_wide; stallb = stall_viol; idleb = idle_read;
        @(negedge clk);
        check("t3h_restart_valid", 64'(tx_valid), 64'd1);
        check("t3h_restart_hdr", 64'(tx_data), 64'hA5);
        start = 1'b0;
        finish_frame("t3h_f2", 1'b0, rxb, rdb, doneb, wideb, stallb, idleb);

        // Reset while bin 1 byte 0 is presented.
        for (int b = 0; b < NBINS; b++) mem[b] = CNT_W'($urandom);
        build_exp();
        ready_pct = 50;
        rxb = rx.size(); doneb = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(tx_valid && rd_addr == 2'd1 && rx.size() - rxb == 4) && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t4_reached", 64'(tx_valid && rd_addr == 2'd1), 64'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("t4_tx_valid", 64'(tx_valid), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_rd_addr", 64'(rd_addr), 64'd0);
        reset_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("t4_nodone", 64'(done_cnt - doneb), 64'd0);
        run_frame("t4_after", 60, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
